// File: rtl/pes_fp_result_fifo.sv
// Result-capture FIFO behind the single-precision add/sub unit: tags accepted operand pairs,
// captures and classifies adder results after LAT clocks, and returns credit to the issuer.
module pes_fp_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = $clog2(DEPTH + LAT + 1);

    logic [LAT-1:0] vp_q, vp_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           proto_err_q, proto_err_d;
    logic [35:0]    mem_q [DEPTH];

    logic [SW-1:0]  inflight;
    logic [SW-1:0]  occupancy;
    logic           acc, push, pop;
    logic [7:0]     res_exp;
    logic [22:0]    res_man;
    logic [3:0]     res_flags;
    logic [35:0]    head;

    // Credit counts results still inside the adder, so a full FIFO can never be overrun.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SW'(vp_q[i]);
        end
        occupancy = SW'(count_q) + inflight;
        in_ready  = occupancy < SW'(DEPTH);
        acc       = in_valid & in_ready;
        push      = vp_q[LAT-1];
        pop       = out_valid & out_ready;
    end

    // Sign is ignored; at most one class bit is ever set.
    always_comb begin
        res_exp   = res[30:23];
        res_man   = res[22:0];
        res_flags = {(&res_exp) & (|res_man),
                     (&res_exp) & ~(|res_man),
                     ~(|res_exp) & ~(|res_man),
                     ~(|res_exp) & (|res_man)};
    end

    always_comb begin
        vp_d        = LAT'({vp_q, acc});
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        proto_err_d = proto_err_q | (in_valid & ~in_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            vp_q        <= vp_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is deliberately not reset; count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_flags, res};
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = count_q != '0;
        out_data  = out_valid ? head[31:0] : 32'h0;
        out_flags = out_valid ? head[35:32] : 4'h0;
        count     = count_q;
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_pes_fp_result_fifo.sv
// Bench for pes_fp_result_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pes_fp_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   res;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_flags;
    logic [CW-1:0] count;
    logic          proto_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [31:0] rline [LAT];

    // Reference model state
    logic [35:0] mq [$];
    int          pend [$];
    int          edge_n = 0;
    bit          m_err = 0;

    pes_fp_result_fifo #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .count     (count),
        .proto_err (proto_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] cls(input logic [31:0] w);
        int e, m;
        e = int'((w >> 23) & 32'hFF);
        m = int'(w & 32'h7FFFFF);
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0, e == 0 && m != 0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy, acc, pop, push, ovf;
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            m_err = 0;
        end else begin
            rdy  = (mq.size() + pend.size()) < DEPTH;
            acc  = in_valid && rdy;
            if (in_valid && !rdy) m_err = 1;
            pop  = (mq.size() > 0) && out_ready;
            push = (pend.size() > 0) && (pend[0] + LAT == edge_n);
            ovf  = push && (mq.size() == DEPTH) && !pop;
            chk("no_overflow", 32'(ovf), 32'd0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                void'(pend.pop_front());
                mq.push_back({cls(res), res});
            end
            if (acc) pend.push_back(edge_n);
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            ev = mq.size() != 0;
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data", out_data, ev ? mq[0][31:0] : 32'h0);
            chk("out_flags", 32'(out_flags), ev ? 32'(mq[0][35:32]) : 32'h0);
            chk("count", 32'(count), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'((mq.size() + pend.size()) < DEPTH));
            chk("proto_err", 32'(proto_err), 32'(m_err));
        end
    end

    // One step: drive between edges; res follows the operand presentation by LAT steps.
    task automatic cyc(input logic iv, input logic [31:0] val, input logic ordy, input bit obey);
        @(posedge clk);
        #2;
        res = rline[LAT-1];
        for (int i = LAT - 1; i > 0; i--) rline[i] = rline[i-1];
        rline[0]  = val;
        out_ready = ordy;
        in_valid  = obey ? in_ready : iv;
    endtask

    task automatic rst_pulse();
        #1;
        rst_n    = 0;
        in_valid = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        cyc(0, 32'h0, 0, 0);
        rst_n = 1;
    endtask

    initial begin
        logic [3:0] fexp [4];
        logic [31:0] fval [4];
        fexp[0] = 4'b1000; fexp[1] = 4'b0100; fexp[2] = 4'b0010; fexp[3] = 4'b0001;
        fval[0] = 32'h7FC00000; fval[1] = 32'hFF800000;
        fval[2] = 32'h80000000; fval[3] = 32'h00000001;
        for (int i = 0; i < LAT; i++) rline[i] = 32'h0;
        rst_n = 1; in_valid = 0; out_ready = 0; res = 32'h0;
        #1 rst_n = 0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);

        // 1.0 + 2.0 = 3.0
        cyc(1, 32'h40400000, 1, 0);
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 1, 0);
        #1 chk("t1_valid_early", 32'(out_valid), 32'd0);
        cyc(0, 32'h0, 1, 0);
        #1;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'h40400000);
        chk("t1_flags", 32'(out_flags), 32'd0);
        cyc(0, 32'h0, 1, 0);
        #1 chk("t1_count", 32'(count), 32'd0);

        // Obedient issuer against a stalled consumer
        for (int i = 0; i < 6; i++) cyc(0, 32'h11 + 32'(i), 0, 1);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        #1;
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_proto", 32'(proto_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 1, 0);
            #1 chk("t2_order", out_data, 32'h11 + 32'(i));
        end
        cyc(0, 32'h0, 0, 0);
        #1 chk("t2_empty", 32'(count), 32'd0);

        // Issuer ignores in_ready
        for (int i = 0; i < 6; i++) cyc(1, 32'h21 + 32'(i), 0, 0);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        #1;
        chk("t3_proto", 32'(proto_err), 32'd1);
        chk("t3_count", 32'(count), 32'd4);
        cyc(0, 32'h0, 0, 0);
        #1 chk("t3_sticky", 32'(proto_err), 32'd1);
        rst_pulse();

        // Classification
        for (int i = 0; i < 4; i++) cyc(0, fval[i], 0, 1);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 1, 0);
            #1;
            chk("t4_flags", 32'(out_flags), 32'(fexp[i]));
            chk("t4_data", out_data, fval[i]);
        end
        cyc(0, 32'h0, 0, 0);

        // Full FIFO drained while issue continues; crosses pointer wrap
        for (int i = 0; i < 4; i++) cyc(0, 32'h61 + 32'(i), 0, 1);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h70, 1, 1);
        #1 chk("t5_ready_full", 32'(in_ready), 32'd0);
        cyc(0, 32'h71, 1, 1);
        #1 chk("t5_ready_credit", 32'(in_ready), 32'd1);
        for (int i = 2; i < 8; i++) cyc(0, 32'h70 + 32'(i), 1, 1);
        for (int i = 0; i < 8; i++) cyc(0, 32'h0, 1, 0);
        #1 chk("t5_drained", 32'(count), 32'd0);

        // Reset with results both stored and in flight
        for (int i = 0; i < 4; i++) cyc(0, 32'h51 + 32'(i), 0, 1);
        cyc(0, 32'h0, 0, 0);
        #1 chk("t6_pre_count", 32'(count), 32'd2);
        rst_pulse();
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0);
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);

        @(posedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
